sync_fifo_ctl: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's basic synchronous FIFO. It adds a selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It sits between producer and consumer datapaths in one clock domain and replaces the plain FIFO wherever flow control needs early warning or zero-latency head visibility.

---
 rtl/sync_fifo_ctl.sv | 112 +++++++++++
 tb/tb_sync_fifo_ctl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctl.sv
// rtl/sync_fifo_ctl.sv - single-clock FIFO with FWFT option, occupancy, thresholds and sticky error flags
module sync_fifo_ctl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     winc,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rinc,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     wfull,
    output logic                     rempty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wen, ren;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [WIDTH-1:0]    head_word;

    // Status is derived from the registered pointers only; requests only steer the next state
    always_comb begin
        wfull        = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                       (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
        rempty       = (wptr_q == rptr_q);
        count        = wptr_q - rptr_q;
        almost_full  = (count >= AFULL_C);
        almost_empty = (count <= AEMPTY_C);
        wen          = winc & ~wfull;
        ren          = rinc & ~rempty;
        wptr_d       = wptr_q + {{ADDR_WIDTH{1'b0}}, wen};
        rptr_d       = rptr_q + {{ADDR_WIDTH{1'b0}}, ren};
        // A new error event in the same cycle as err_clr keeps the flag set
        overflow_d   = (overflow_q & ~err_clr) | (winc & wfull);
        underflow_d  = (underflow_q & ~err_clr) | (rinc & rempty);
        overflow     = overflow_q;
        underflow    = underflow_q;
        head_word    = mem[rptr_q[ADDR_WIDTH-1:0]];
    end

    // Pointer and sticky error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible combinationally whenever the FIFO is non-empty
            always_comb begin
                rdata  = head_word;
                rvalid = ~rempty;
            end
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q, rdata_d;
            logic             rvalid_q, rvalid_d;

            // Registered read: data captured on an accepted read, held otherwise
            always_comb begin
                rdata_d  = ren ? head_word : rdata_q;
                rvalid_d = ren;
                rdata    = rdata_q;
                rvalid   = rvalid_q;
            end

            // Read data output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb/tb_sync_fifo_ctl.sv - scoreboard testbench for sync_fifo_ctl in registered and FWFT modes
module tb_sync_fifo_ctl;

    logic       clk;
    logic       rst_n;

    logic       winc0, rinc0, clr0;
    logic [7:0] wdata0, rdata0;
    logic       rvalid0, wfull0, rempty0, afull0, aempty0, ovf0, udf0;
    logic [4:0] count0;

    logic       winc1, rinc1, clr1;
    logic [7:0] wdata1, rdata1;
    logic       rvalid1, wfull1, rempty1, afull1, aempty1, ovf1, udf1;
    logic [4:0] count1;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] sb[$];
    int         m_count = 0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    sync_fifo_ctl #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .winc(winc0), .wdata(wdata0), .rinc(rinc0), .err_clr(clr0),
        .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
        .almost_full(afull0), .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_ctl #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .winc(winc1), .wdata(wdata1), .rinc(rinc1), .err_clr(clr1),
        .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
        .almost_full(afull1), .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus on the registered-read instance; model and scoreboard advance with it
    task automatic cycle0(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic wen, ren;
        wen   = w && (m_count < 16);
        ren   = r && (m_count > 0);
        m_ovf = (m_ovf && !c) || (w && m_count == 16);
        m_udf = (m_udf && !c) || (r && m_count == 0);
        if (ren) m_rdata = sb.pop_front();
        if (wen) sb.push_back(d);
        m_count = m_count + int'(wen) - int'(ren);
        winc0 = w; wdata0 = d; rinc0 = r; clr0 = c;
        @(posedge clk); #1;
        winc0 = 1'b0; rinc0 = 1'b0; clr0 = 1'b0;
        checks++;
        if (rvalid0 !== ren) begin
            errors++;
            $display("FAIL rvalid: got %b exp %b", rvalid0, ren);
        end
        checks++;
        if (rdata0 !== m_rdata) begin
            errors++;
            $display("FAIL rdata: got %02h exp %02h", rdata0, m_rdata);
        end
    endtask

    task automatic fill_to(input int n);
        while (m_count < n) cycle0(1'b1, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drain_to(input int n);
        while (m_count > n) cycle0(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        checks++;
        if ({count0, rempty0, wfull0, aempty0, afull0, rvalid0, rdata0, ovf0, udf0} !==
            {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset0: got cnt=%0d e=%b f=%b ae=%b af=%b v=%b d=%02h o=%b u=%b exp 0 1 0 1 0 0 00 0 0",
                     count0, rempty0, wfull0, aempty0, afull0, rvalid0, rdata0, ovf0, udf0);
        end
        checks++;
        if ({rempty1, rvalid1, count1} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset1: got e=%b v=%b cnt=%0d exp 1 0 0", rempty1, rvalid1, count1);
        end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 16; i++) begin
            cycle0(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if ({count0, afull0, aempty0, wfull0, rempty0} !==
                {5'(i + 1), (i + 1 >= 14), (i + 1 <= 1), (i == 15), 1'b0}) begin
                errors++;
                $display("FAIL fill: got cnt=%0d af=%b ae=%b f=%b e=%b exp cnt=%0d", count0, afull0, aempty0, wfull0, rempty0, i + 1);
            end
        end
        for (int i = 0; i < 16; i++) begin
            cycle0(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if ({count0, wfull0, rempty0} !== {5'(15 - i), 1'b0, (i == 15)}) begin
                errors++;
                $display("FAIL drain: got cnt=%0d f=%b e=%b exp cnt=%0d", count0, wfull0, rempty0, 15 - i);
            end
        end
    endtask

    task automatic test_overflow_underflow;
        fill_to(16);
        cycle0(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if ({ovf0, count0, wfull0} !== {1'b1, 5'd16, 1'b1}) begin
            errors++;
            $display("FAIL overflow: got o=%b cnt=%0d f=%b exp 1 16 1", ovf0, count0, wfull0);
        end
        drain_to(0);
        cycle0(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({udf0, count0, rempty0} !== {1'b1, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL underflow: got u=%b cnt=%0d e=%b exp 1 0 1", udf0, count0, rempty0);
        end
        cycle0(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({ovf0, udf0} !== 2'b00) begin
            errors++;
            $display("FAIL err_clr: got o=%b u=%b exp 0 0", ovf0, udf0);
        end
        cycle0(1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (udf0 !== m_udf || m_udf !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got u=%b exp 1", udf0);
        end
        cycle0(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous;
        fill_to(16);
        cycle0(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if ({count0, ovf0, udf0} !== {5'd15, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL simul_full: got cnt=%0d o=%b u=%b exp 15 1 0", count0, ovf0, udf0);
        end
        cycle0(1'b0, 8'h00, 1'b0, 1'b1);
        drain_to(0);
        cycle0(1'b1, 8'h66, 1'b1, 1'b0);
        checks++;
        if ({count0, ovf0, udf0} !== {5'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL simul_empty: got cnt=%0d o=%b u=%b exp 1 0 1", count0, ovf0, udf0);
        end
        cycle0(1'b0, 8'h00, 1'b0, 1'b1);
        fill_to(5);
        cycle0(1'b1, 8'h77, 1'b1, 1'b0);
        checks++;
        if ({count0, ovf0, udf0} !== {5'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL simul_mid: got cnt=%0d o=%b u=%b exp 5 0 0", count0, ovf0, udf0);
        end
        drain_to(0);
    endtask

    task automatic test_fwft;
        winc1 = 1'b1; wdata1 = 8'h3C;
        @(posedge clk); #1;
        winc1 = 1'b0;
        checks++;
        if ({rvalid1, rdata1, rempty1, count1} !== {1'b1, 8'h3C, 1'b0, 5'd1}) begin
            errors++;
            $display("FAIL fwft_head: got v=%b d=%02h e=%b cnt=%0d exp 1 3c 0 1", rvalid1, rdata1, rempty1, count1);
        end
        rinc1 = 1'b1;
        @(posedge clk); #1;
        rinc1 = 1'b0;
        checks++;
        if ({rempty1, rvalid1, count1} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL fwft_pop: got e=%b v=%b cnt=%0d exp 1 0 0", rempty1, rvalid1, count1);
        end
    endtask

    task automatic test_wrap;
        int   writes = 0;
        int   iter = 0;
        logic w, r;
        fill_to(3);
        while (writes < 40 && iter < 2000) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (m_count >= 8) w = 1'b0;
            if (m_count <= 3) r = 1'b0;
            if (w) writes++;
            cycle0(w, 8'($urandom), r, 1'b0);
            iter++;
            checks++;
            if ({count0, wfull0, rempty0} !== {5'(m_count), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL wrap: got cnt=%0d f=%b e=%b exp cnt=%0d f=0 e=0", count0, wfull0, rempty0, m_count);
            end
        end
        checks++;
        if (writes < 40) begin
            errors++;
            $display("FAIL wrap_budget: got %0d writes exp 40", writes);
        end
    endtask

    task automatic test_reset_mid;
        drain_to(0);
        cycle0(1'b0, 8'h00, 1'b1, 1'b0);
        fill_to(8);
        cycle0(1'b0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({count0, rempty0, rvalid0, ovf0, udf0, wfull0} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got cnt=%0d e=%b v=%b o=%b u=%b f=%b exp 0 1 0 0 0 0",
                     count0, rempty0, rvalid0, ovf0, udf0, wfull0);
        end
        sb.delete();
        m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
        #2;
        rst_n = 1'b1;
        cycle0(1'b1, 8'hC3, 1'b0, 1'b0);
        checks++;
        if (count0 !== 5'd1) begin
            errors++;
            $display("FAIL reset_mid_write: got cnt=%0d exp 1", count0);
        end
        cycle0(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        winc0 = 1'b0; rinc0 = 1'b0; clr0 = 1'b0; wdata0 = 8'h00;
        winc1 = 1'b0; rinc1 = 1'b0; clr1 = 1'b0; wdata1 = 8'h00;
        @(posedge clk); #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_fill_drain;
        test_overflow_underflow;
        test_simultaneous;
        test_fwft;
        test_wrap;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
